// File: rtl/xor_frame_parity.sv
// rtl/xor_frame_parity.sv - per-frame one-count and parity of a 2-bit XOR beat stream
// The next frame keeps accumulating while the previous result waits on out_ready.

module xor_frame_parity #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_flush,
  output logic [CNT_W:0]   out_ones,
  output logic             out_parity,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   acc;
  logic             last_beat;
  logic             accept;
  logic             beat_xor;
  logic [CNT_W:0]   sum;

  assign last_beat = (cnt == LAST_IDX);
  assign beat_xor  = in_data[0] ^ in_data[1];
  assign sum       = acc + {{CNT_W{1'b0}}, beat_xor};

  // Only the closing beat must stall, and only while the output slot cannot free up this cycle.
  assign in_ready = !reset && !in_flush && !(last_beat && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      acc        <= '0;
      out_ones   <= '0;
      out_parity <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (in_flush) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        if (last_beat) begin
          out_ones   <= sum;
          out_parity <= sum[0];
          out_valid  <= 1'b1;
          cnt        <= '0;
          acc        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_frame_parity.sv
// tb/tb_xor_frame_parity.sv - scoreboard bench for xor_frame_parity
// A frame model fills expected results; the monitor compares whatever the DUT presents.

module tb_xor_frame_parity;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_flush;
  logic [CNT_W:0]   out_ones;
  logic             out_parity;
  logic             out_valid;
  logic             out_ready;

  int vectors     = 0;
  int miscompares = 0;
  bit rnd_ready   = 1'b0;

  int frame_q[$];
  int exp_q[$];

  xor_frame_parity #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flush  (in_flush),
    .out_ones  (out_ones),
    .out_parity(out_parity),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of XOR bits; a full list becomes its sum.
  always begin
    bit s_reset, s_flush, s_acc;
    int s_bit, total;
    @(negedge clock);
    s_reset = reset;
    s_flush = in_flush;
    s_acc   = in_valid && in_ready;
    s_bit   = in_data[0] ^ in_data[1];
    @(posedge clock);
    if (s_reset) begin
      frame_q.delete();
      exp_q.delete();
    end else if (s_flush) begin
      frame_q.delete();
    end else if (s_acc) begin
      frame_q.push_back(s_bit);
      if (frame_q.size() == FRAME_LEN) begin
        total = 0;
        foreach (frame_q[i]) total += frame_q[i];
        exp_q.push_back(total);
        frame_q.delete();
      end
    end
  end

  // Monitor: pending results are consumed in order; values must hold until drained.
  always @(negedge clock) begin
    bit pend, exp_rdy;
    pend    = exp_q.size() != 0;
    exp_rdy = !reset && !in_flush &&
              !((frame_q.size() == FRAME_LEN - 1) && pend && !out_ready);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("out_valid", int'(out_valid), int'(pend));
    if (out_valid && pend) begin
      chk("out_ones", int'(out_ones), exp_q[0]);
      chk("out_parity", int'(out_parity), exp_q[0] % 2);
      if (out_ready && !reset) void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [1:0] d);
    bit took;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      @(negedge clock);
      took = in_ready;
      tick();
      n++;
    end while (!took && n < 200);
    if (!took) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic send_list(input logic [1:0] beats[], input int cnt);
    for (int i = 0; i < cnt; i++) send_beat(beats[i]);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] b[];
    int n;
    reset = 1'b1; in_data = 2'b00; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("reset_out_ones", int'(out_ones), 0);
    tick();

    // Single frames with varied content
    b = '{2'b00, 2'b10, 2'b01, 2'b11}; send_list(b, 4); tick(); tick();
    b = '{2'b10, 2'b01, 2'b10, 2'b00}; send_list(b, 4); tick();
    b = '{2'b11, 2'b00, 2'b11, 2'b00}; send_list(b, 4); tick(); tick();

    // Backpressure: closing beat of frame 2 stalls until frame 1 drains
    out_ready = 1'b0;
    b = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    send_list(b, 7);
    in_valid = 1'b1; in_data = 2'b01;
    tick(); tick(); tick();
    out_ready = 1'b1;
    send_beat(2'b01);
    in_valid = 1'b0;
    tick(); tick();

    // Flush discards a partial frame and blocks the beat offered with it
    b = '{2'b10, 2'b10}; send_list(b, 2);
    in_flush = 1'b1; in_valid = 1'b1; in_data = 2'b10;
    tick();
    in_flush = 1'b0; in_valid = 1'b0;
    b = '{2'b01, 2'b01, 2'b01, 2'b01}; send_list(b, 4); tick(); tick();

    // Reset with a pending result and a partial frame
    out_ready = 1'b0;
    b = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10}; send_list(b, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_ones", int'(out_ones), 0);
    chk("post_reset_parity", int'(out_parity), 0);
    tick();
    out_ready = 1'b1;
    b = '{2'b10, 2'b00, 2'b00, 2'b00}; send_list(b, 4); tick(); tick();

    // Gaps between beats do not count
    in_valid = 1'b1; in_data = 2'b10; send_beat(2'b10);
    in_valid = 1'b0; in_data = 2'b11; tick(); tick();
    send_beat(2'b10);
    in_valid = 1'b0; in_data = 2'b00; tick();
    send_beat(2'b01); send_beat(2'b01);
    in_valid = 1'b0;
    tick(); tick();

    // Randomized traffic with random backpressure and rare flushes
    rnd_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 2'($urandom_range(0, 3));
      in_flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    rnd_ready = 1'b0;
    in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b1;

    n = 0;
    while (out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(out_valid), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
